// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment driver: scans both players' digits onto a
// shared segment bus with per-slot dead time, per-player blink and a colon DP.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLANK_CYC      = 50,
  parameter int unsigned BLINK_DIV      = 25000000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter logic [7:0]  DP_MASK        = 8'b01000100
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic [6:0] seg0_0,
  input  logic [6:0] seg0_1,
  input  logic [6:0] seg0_2,
  input  logic [6:0] seg0_3,
  input  logic [6:0] seg1_0,
  input  logic [6:0] seg1_1,
  input  logic [6:0] seg1_2,
  input  logic [6:0] seg1_3,
  input  logic       BLINK_P1,
  input  logic       BLINK_P2,
  input  logic       COLON_EN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [7:0] AN
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);
  localparam logic [6:0]       SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [6:0]       snap_q, snap_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic [6:0] in_sel;
  logic       in_blank;
  logic       suppress;

  always_comb begin
    in_sel = seg1_3;
    case (idx_q)
      3'd0:    in_sel = seg0_0;
      3'd1:    in_sel = seg0_1;
      3'd2:    in_sel = seg0_2;
      3'd3:    in_sel = seg0_3;
      3'd4:    in_sel = seg1_0;
      3'd5:    in_sel = seg1_1;
      3'd6:    in_sel = seg1_2;
      default: in_sel = seg1_3;
    endcase
  end

  assign in_blank = (cnt_q < CNT_BLANK);
  // Blink suppression reads BLINK_Px live so release is seen at the next update.
  assign suppress = phase_q & (idx_q[2] ? BLINK_P2 : BLINK_P1);

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (CE) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // The snapshot keeps tracking the selected input through dead time, even with CE low.
  always_comb begin
    snap_d = in_blank ? in_sel : snap_q;
  end

  always_comb begin
    an_d  = 8'hFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!in_blank && !suppress) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = snap_q;
      dp_d  = ~(COLON_EN & DP_MASK[idx_q]);
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      snap_q      <= SEG_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      an_q        <= 8'hFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a tick-count based display model.
module tb_seg_scan_driver;

  localparam int         SCAN_DIV  = 4;
  localparam int         BLANK_CYC = 1;
  localparam int         BLINK_DIV = 8;
  localparam logic [7:0] DPM_P     = 8'b01000100;
  localparam logic [6:0] OFF       = 7'h7F;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       CE;
  logic [6:0] code [8];
  logic       BLINK_P1, BLINK_P2, COLON_EN;
  logic [6:0] SEG;
  logic       DP;
  logic [7:0] AN;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: enabled-tick count since reset plus the latched digit code.
  int         t;
  logic [6:0] snap_m;
  logic [7:0] last_an;
  int         gap;
  logic [7:0] dpm = DPM_P;

  logic [7:0] tbl_an  [8] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD};
  logic [6:0] tbl_seg [8] = '{7'h7F, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h79, 7'h79, 7'h79};

  seg_scan_driver #(
    .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLINK_DIV(BLINK_DIV),
    .SEG_ACTIVE_LOW(1'b1), .DP_MASK(DPM_P)
  ) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE),
    .seg0_0(code[0]), .seg0_1(code[1]), .seg0_2(code[2]), .seg0_3(code[3]),
    .seg1_0(code[4]), .seg1_1(code[5]), .seg1_2(code[6]), .seg1_3(code[7]),
    .BLINK_P1(BLINK_P1), .BLINK_P2(BLINK_P2), .COLON_EN(COLON_EN),
    .SEG(SEG), .DP(DP), .AN(AN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    t       = 0;
    snap_m  = OFF;
    last_an = 8'hFF;
    gap     = 0;
  endtask

  // One clock: predict the registered outputs from the pre-edge model, then compare.
  task automatic step();
    int pos, idx, ph;
    bit sup;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    pos = t % SCAN_DIV;
    idx = (t / SCAN_DIV) % 8;
    ph  = (t / BLINK_DIV) % 2;
    sup = (ph == 1) && ((idx < 4) ? BLINK_P1 : BLINK_P2);
    if (pos < BLANK_CYC || sup) begin
      e_an = 8'hFF; e_seg = OFF; e_dp = 1'b1;
    end else begin
      e_an = ~(8'h01 << idx); e_seg = snap_m; e_dp = ~(COLON_EN & dpm[idx]);
    end
    if (pos < BLANK_CYC) snap_m = code[idx];
    if (CE) t++;
    @(posedge CLK); #1;
    chk("an", AN, e_an);
    chk("seg", SEG, e_seg);
    chk("dp", DP, e_dp);
    chk("an_onehot", ($countones(~AN) <= 1), 1);
    chk("colon_rule", DP, !(COLON_EN && (AN == 8'hBF || AN == 8'hFB)));
    if (AN == 8'hFF) gap++;
    else begin
      if (last_an != 8'hFF && AN != last_an) chk("blank_gap", (gap >= BLANK_CYC), 1);
      gap = 0;
      last_an = AN;
    end
  endtask

  initial begin
    int j;
    int n;
    logic [7:0] e;
    CLR = 1'b0; CE = 1'b1;
    BLINK_P1 = 1'b0; BLINK_P2 = 1'b0; COLON_EN = 1'b0;
    for (int i = 0; i < 8; i++) code[i] = 7'h24;
    code[0] = 7'h40; code[1] = 7'h79;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_an", AN, 8'hFF);
    chk("rst_seg", SEG, 7'h7F);
    chk("rst_dp", DP, 1'b1);
    CLR = 1'b1;

    // Directed scan sequence from release.
    for (int k = 0; k < 8; k++) begin
      step();
      chk("scan_an", AN, tbl_an[k]);
      chk("scan_seg", SEG, tbl_seg[k]);
    end
    for (int k = 8; k < 34; k++) step();
    chk("repeat_an", AN, 8'hFE);
    chk("repeat_seg", SEG, 7'h40);

    // Mid-slot input change must wait for the next idx-0 slot.
    code[0] = 7'h12;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("midslot_seg", SEG, 7'h40);
    end
    for (int k = 36; k < 66; k++) step();
    chk("nextslot_an", AN, 8'hFE);
    chk("nextslot_seg", SEG, 7'h12);

    // Colon.
    COLON_EN = 1'b1;
    repeat (40) step();
    COLON_EN = 1'b0;
    repeat (8) step();

    // Blink on player 2 with changing codes.
    BLINK_P2 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, 7);
        code[j] = 7'($urandom);
      end
      step();
    end
    for (int i = 0; i < 64 && !(((t / BLINK_DIV) % 2 == 1) && ((t / SCAN_DIV) % 8 >= 4)
         && (t % SCAN_DIV >= BLANK_CYC)); i++) step();
    BLINK_P2 = 1'b0;
    e = ~(8'h01 << ((t / SCAN_DIV) % 8));
    step();
    chk("blink_drop", AN, e);

    // CE freeze during DRIVE of idx 3.
    for (int i = 0; i < 40 && (t % 32) != 0; i++) step();
    code[3] = 7'h30;
    for (int i = 0; i < 40 && (t % 32) != 14; i++) step();
    CE = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("freeze_an", AN, 8'hF7);
      chk("freeze_seg", SEG, 7'h30);
    end
    CE = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && AN != 8'hFF; i++) begin
      step();
      if (AN == 8'hF7) n++;
    end
    chk("ce_resume_cycles", n, 2);

    // Asynchronous reset mid-DRIVE.
    for (int i = 0; i < 40 && (t % 32) != 6; i++) step();
    step();
    chk("pre_rst_an", AN, 8'hFD);
    #2 CLR = 1'b0;
    #1;
    chk("arst_an", AN, 8'hFF);
    chk("arst_seg", SEG, 7'h7F);
    chk("arst_dp", DP, 1'b1);
    @(posedge CLK); #1;
    CLR = 1'b1;
    model_reset();
    step();
    chk("post_rst_c1", AN, 8'hFF);
    step();
    chk("post_rst_c2", AN, 8'hFE);

    // Randomized run.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        j = $urandom_range(0, 7);
        code[j] = 7'($urandom);
      end
      CE = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) BLINK_P1 = ~BLINK_P1;
      if ($urandom_range(0, 15) == 0) BLINK_P2 = ~BLINK_P2;
      if ($urandom_range(0, 15) == 0) COLON_EN = ~COLON_EN;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
